// File: rtl/layer_sequencer_pkg.sv
// Shared definitions for the layer sequencer: controller state encoding and the
// "no neuron selected" configuration value.
package layer_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FEED  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    localparam logic [31:0] CFG_NONE = 32'hFFFF_FFFF;

endpackage

// File: rtl/layer_sequencer.sv
// One-layer controller: streams weights into the neuron array, broadcasts activations,
// collects per-neuron results and serialises them to the next layer.
module layer_sequencer
    import layer_sequencer_pkg::*;
#(
    parameter int layerNo   = 0,
    parameter int numNeuron = 4,
    parameter int numWeight = 10,
    parameter int dataWidth = 16,
    parameter int timeout   = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           load_start,
    input  logic                           s_wvalid,
    input  logic [31:0]                    s_wdata,
    output logic                           s_wready,
    output logic [$clog2(numWeight)-1:0]   in_rd_addr,
    input  logic [dataWidth-1:0]           in_rd_data,
    output logic [dataWidth-1:0]           neuron_in,
    output logic                           neuron_in_valid,
    output logic                           weightValid,
    output logic [31:0]                    weightValue,
    output logic [31:0]                    config_layer_num,
    output logic [31:0]                    config_neuron_num,
    input  logic [numNeuron-1:0]           neuron_outvalid,
    input  logic [numNeuron*dataWidth-1:0] neuron_out,
    output logic                           out_valid,
    output logic [dataWidth-1:0]           out_data,
    output logic [$clog2(numNeuron)-1:0]   out_idx,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);

    localparam int AW = $clog2(numWeight);
    localparam int NW = $clog2(numNeuron);
    localparam int TW = $clog2(timeout + 1);

    state_t                 state;
    state_t                 state_next;
    logic [AW-1:0]          addr_cnt;
    logic                   feed_tail;
    logic [AW-1:0]          w_cnt;
    logic [NW-1:0]          n_cnt;
    logic [TW-1:0]          wait_cnt;
    logic [numNeuron-1:0]   captured;
    logic [dataWidth-1:0]   results [numNeuron];
    logic                   in_valid_q;
    logic                   accept;
    logic                   load_last;
    logic                   drain_last;
    logic                   timed_out;

    assign accept     = (state == ST_LOAD) && s_wvalid;
    assign load_last  = accept && (w_cnt == AW'(numWeight - 1)) && (n_cnt == NW'(numNeuron - 1));
    assign drain_last = (state == ST_DRAIN) && (n_cnt == NW'(numNeuron - 1));
    assign timed_out  = (state == ST_WAIT) && !(&captured) && (wait_cnt == TW'(timeout - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Load request wins over start when both arrive together in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (load_start) state_next = ST_LOAD;
                      else if (start) state_next = ST_FEED;
            ST_LOAD:  if (load_last) state_next = ST_IDLE;
            ST_FEED:  if (feed_tail) state_next = ST_WAIT;
            ST_WAIT:  if (&captured) state_next = ST_DRAIN;
                      else if (timed_out) state_next = ST_IDLE;
            ST_DRAIN: if (drain_last) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        s_wready          = (state == ST_LOAD);
        weightValid       = accept;
        weightValue       = accept ? s_wdata : 32'd0;
        config_layer_num  = 32'(layerNo);
        config_neuron_num = (state == ST_LOAD) ? 32'(n_cnt) : CFG_NONE;
        in_rd_addr        = (state == ST_FEED) ? addr_cnt : '0;
        out_valid         = (state == ST_DRAIN);
        out_idx           = (state == ST_DRAIN) ? n_cnt : '0;
        out_data          = (state == ST_DRAIN) ? results[n_cnt] : '0;
        busy              = (state != ST_IDLE);
    end

    // The buffer has one cycle of read latency, so its data lines up with the
    // registered valid and is forwarded directly.
    assign neuron_in_valid = in_valid_q;
    assign neuron_in       = in_valid_q ? in_rd_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_cnt   <= '0;
            feed_tail  <= 1'b0;
            w_cnt      <= '0;
            n_cnt      <= '0;
            wait_cnt   <= '0;
            captured   <= '0;
            in_valid_q <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            for (int n = 0; n < numNeuron; n++) results[n] <= '0;
        end else begin
            done       <= 1'b0;
            err        <= 1'b0;
            in_valid_q <= (state == ST_FEED) && !feed_tail;
            case (state)
                ST_IDLE: begin
                    addr_cnt  <= '0;
                    feed_tail <= 1'b0;
                    w_cnt     <= '0;
                    n_cnt     <= '0;
                    wait_cnt  <= '0;
                end
                ST_LOAD: begin
                    if (accept) begin
                        if (w_cnt == AW'(numWeight - 1)) begin
                            w_cnt <= '0;
                            if (n_cnt != NW'(numNeuron - 1)) n_cnt <= n_cnt + NW'(1);
                        end else begin
                            w_cnt <= w_cnt + AW'(1);
                        end
                    end
                    if (load_last) begin
                        done  <= 1'b1;
                        n_cnt <= '0;
                    end
                end
                // One extra tail cycle lets the last broadcast pulse finish before WAIT.
                ST_FEED: begin
                    wait_cnt <= '0;
                    captured <= '0;
                    if (!feed_tail) begin
                        if (addr_cnt == AW'(numWeight - 1)) begin
                            addr_cnt  <= '0;
                            feed_tail <= 1'b1;
                        end else begin
                            addr_cnt <= addr_cnt + AW'(1);
                        end
                    end else begin
                        feed_tail <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt + TW'(1);
                    for (int n = 0; n < numNeuron; n++) begin
                        if (neuron_outvalid[n] && !captured[n]) begin
                            results[n]  <= neuron_out[n*dataWidth +: dataWidth];
                            captured[n] <= 1'b1;
                        end
                    end
                    if (timed_out) begin
                        err      <= 1'b1;
                        captured <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (drain_last) begin
                        done     <= 1'b1;
                        captured <= '0;
                        n_cnt    <= '0;
                    end else begin
                        n_cnt <= n_cnt + NW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: stimulus pushes expected events, a negedge
// monitor pops and compares every weight strobe, broadcast, result, done and err.
module tb_layer_sequencer;

    typedef enum int {EV_WGT, EV_ACT, EV_RES, EV_DONE, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [31:0] a;
        logic [31:0] b;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        load_start;
    logic        s_wvalid;
    logic [31:0] s_wdata;
    logic        s_wready;
    logic [3:0]  in_rd_addr;
    logic [15:0] in_rd_data;
    logic [15:0] neuron_in;
    logic        neuron_in_valid;
    logic        weightValid;
    logic [31:0] weightValue;
    logic [31:0] config_layer_num;
    logic [31:0] config_neuron_num;
    logic [3:0]  neuron_outvalid;
    logic [63:0] neuron_out;
    logic        out_valid;
    logic [15:0] out_data;
    logic [1:0]  out_idx;
    logic        busy;
    logic        done;
    logic        err;

    ev_t         exp_q[$];
    logic [15:0] buffer [10];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_cyc = -1;
    int          err_cyc = -1;
    logic        err_busy = 1'b1;

    layer_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .load_start(load_start),
        .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wready(s_wready),
        .in_rd_addr(in_rd_addr), .in_rd_data(in_rd_data),
        .neuron_in(neuron_in), .neuron_in_valid(neuron_in_valid),
        .weightValid(weightValid), .weightValue(weightValue),
        .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
        .neuron_outvalid(neuron_outvalid), .neuron_out(neuron_out),
        .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Activation buffer with one cycle of read latency.
    always @(posedge clk) in_rd_data <= buffer[in_rd_addr];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic observe(input ev_kind_t kind, input logic [31:0] a, input logic [31:0] b);
        ev_t e;
        if (kind == EV_DONE) done_cyc = cyc;
        if (kind == EV_ERR) begin
            err_cyc  = cyc;
            err_busy = busy;
        end
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected %s event: got a=%h b=%h, expected no event", kind.name(), a, b);
        end else begin
            e = exp_q.pop_front();
            checkOutput("event kind", 32'(kind), 32'(e.kind));
            checkOutput({kind.name(), " field a"}, a, e.a);
            checkOutput({kind.name(), " field b"}, b, e.b);
        end
    endtask

    always @(negedge clk) begin
        if (weightValid)     observe(EV_WGT, weightValue, config_neuron_num);
        if (neuron_in_valid) observe(EV_ACT, 32'(neuron_in), 32'd0);
        if (out_valid)       observe(EV_RES, 32'(out_idx), 32'(out_data));
        if (done)            observe(EV_DONE, 32'd0, 32'd0);
        if (err)             observe(EV_ERR, 32'd0, 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expectEvent(input ev_kind_t kind, input logic [31:0] a, input logic [31:0] b);
        ev_t e;
        e.kind = kind;
        e.a    = a;
        e.b    = b;
        exp_q.push_back(e);
    endtask

    task automatic waitDrain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checkOutput({name, " pending events"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse(input logic [3:0] mask, input logic [63:0] data);
        neuron_outvalid = mask;
        neuron_out      = data;
        tick();
        neuron_outvalid = 4'd0;
    endtask

    task automatic startFeed();
        for (int i = 0; i < 10; i++) expectEvent(EV_ACT, 32'(i + 1), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic applyStimulus();
        int base;
        int entry;

        // Reset values
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset s_wready", 32'(s_wready), 32'd0);
        checkOutput("reset weightValid", 32'(weightValid), 32'd0);
        checkOutput("reset neuron_in_valid", 32'(neuron_in_valid), 32'd0);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset err", 32'(err), 32'd0);
        checkOutput("reset config_neuron_num", config_neuron_num, 32'hFFFF_FFFF);
        checkOutput("reset config_layer_num", config_layer_num, 32'd0);
        checkOutput("reset in_rd_addr", 32'(in_rd_addr), 32'd0);
        rst = 1'b0;
        tick();

        $display("[TB] weight load with s_wvalid held");
        for (int k = 1; k <= 40; k++) expectEvent(EV_WGT, 32'(k), 32'((k - 1) / 10));
        expectEvent(EV_DONE, 32'd0, 32'd0);
        base       = cyc;
        load_start = 1'b1;
        s_wvalid   = 1'b1;
        s_wdata    = 32'd1;
        tick();
        load_start = 1'b0;
        for (int k = 2; k <= 40; k++) begin
            tick();
            s_wdata = 32'(k);
        end
        tick();
        s_wvalid = 1'b0;
        checkOutput("load end s_wready", 32'(s_wready), 32'd0);
        checkOutput("load end config_neuron_num", config_neuron_num, 32'hFFFF_FFFF);
        tick();
        checkOutput("load done cycle", 32'(done_cyc - base), 32'd41);
        waitDrain("load held", 5);

        $display("[TB] weight load with s_wvalid toggling");
        for (int j = 0; j < 40; j++) expectEvent(EV_WGT, 32'(101 + j), 32'(j / 10));
        expectEvent(EV_DONE, 32'd0, 32'd0);
        base       = cyc;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int c = 0; c < 80; c++) begin
            s_wvalid = (c % 2 == 0);
            s_wdata  = 32'(101 + c / 2);
            tick();
        end
        s_wvalid = 1'b0;
        checkOutput("toggle done cycle", 32'(done_cyc - base), 32'd80);
        waitDrain("load toggle", 5);
        checkOutput("toggle busy after", 32'(busy), 32'd0);

        $display("[TB] inference, out-of-order responses, stray pulse during feed");
        startFeed();
        tick();
        tick();
        pulse(4'b0001, 64'h0000_0000_0000_DEAD);
        waitDrain("feed A", 30);
        expectEvent(EV_RES, 32'd0, 32'h0011);
        expectEvent(EV_RES, 32'd1, 32'h0022);
        expectEvent(EV_RES, 32'd2, 32'h0033);
        expectEvent(EV_RES, 32'd3, 32'h0044);
        expectEvent(EV_DONE, 32'd0, 32'd0);
        pulse(4'b0100, 64'h0000_0033_0000_0000);
        pulse(4'b0001, 64'h0000_0000_0000_0011);
        pulse(4'b1000, 64'h0044_0000_0000_0000);
        pulse(4'b0010, 64'h0000_0000_0022_0000);
        waitDrain("drain A", 20);
        checkOutput("pass A busy after", 32'(busy), 32'd0);

        $display("[TB] neuron 3 never responds");
        startFeed();
        waitDrain("feed T", 30);
        entry = cyc;
        expectEvent(EV_ERR, 32'd0, 32'd0);
        pulse(4'b0111, 64'h0000_3333_2222_1111);
        waitDrain("timeout", 100);
        checkOutput("timeout err cycle", 32'(err_cyc - entry), 32'd64);
        checkOutput("timeout busy at err", 32'(err_busy), 32'd0);
        checkOutput("timeout busy after", 32'(busy), 32'd0);

        $display("[TB] duplicate pulse from neuron 2");
        startFeed();
        waitDrain("feed D", 30);
        expectEvent(EV_RES, 32'd0, 32'h0101);
        expectEvent(EV_RES, 32'd1, 32'h0202);
        expectEvent(EV_RES, 32'd2, 32'h0AAA);
        expectEvent(EV_RES, 32'd3, 32'h0303);
        expectEvent(EV_DONE, 32'd0, 32'd0);
        pulse(4'b0100, 64'h0000_0AAA_0000_0000);
        pulse(4'b0101, 64'h0000_0BBB_0000_0101);
        pulse(4'b1010, 64'h0303_0000_0202_0000);
        waitDrain("drain D", 20);

        $display("[TB] reset mid-feed");
        startFeed();
        for (int i = 0; i < 20 && in_rd_addr != 4'd5; i++) tick();
        checkOutput("feed addr before reset", 32'(in_rd_addr), 32'd5);
        rst = 1'b1;
        tick();
        checkOutput("post-reset busy", 32'(busy), 32'd0);
        checkOutput("post-reset neuron_in_valid", 32'(neuron_in_valid), 32'd0);
        checkOutput("post-reset in_rd_addr", 32'(in_rd_addr), 32'd0);
        checkOutput("post-reset config_neuron_num", config_neuron_num, 32'hFFFF_FFFF);
        rst = 1'b0;
        checkOutput("broadcasts left after reset", 32'(exp_q.size()), 32'd5);
        exp_q.delete();
        tick();

        startFeed();
        waitDrain("feed R", 30);
        expectEvent(EV_RES, 32'd0, 32'h1001);
        expectEvent(EV_RES, 32'd1, 32'h1002);
        expectEvent(EV_RES, 32'd2, 32'h1003);
        expectEvent(EV_RES, 32'd3, 32'h1004);
        expectEvent(EV_DONE, 32'd0, 32'd0);
        pulse(4'b1111, 64'h1004_1003_1002_1001);
        waitDrain("drain R", 20);

        $display("[TB] start and load_start together");
        start      = 1'b1;
        load_start = 1'b1;
        tick();
        start      = 1'b0;
        load_start = 1'b0;
        checkOutput("both s_wready", 32'(s_wready), 32'd1);
        checkOutput("both busy", 32'(busy), 32'd1);
        checkOutput("both config_neuron_num", config_neuron_num, 32'd0);
        tick();
        checkOutput("both in_rd_addr", 32'(in_rd_addr), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        checkOutput("final busy", 32'(busy), 32'd0);
        waitDrain("final", 2);
    endtask

    initial begin
        for (int i = 0; i < 10; i++) buffer[i] = 16'(i + 1);
        rst             = 1'b1;
        start           = 1'b0;
        load_start      = 1'b0;
        s_wvalid        = 1'b0;
        s_wdata         = 32'd0;
        neuron_outvalid = 4'd0;
        neuron_out      = 64'd0;
        repeat (3) tick();
        applyStimulus();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
